// File: rtl/uar_pkg.sv
// ============================================================================
// uar_pkg : shared codes, frame lengths and parser states for uar_cmd_decoder
// Revision : 1.0
// ============================================================================
`default_nettype none

package uar_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam logic [7:0] CMD_WRITE_DEF  = 8'h01;
  localparam logic [7:0] CMD_READ_DEF   = 8'h02;

  localparam int READ_FRAME_LEN  = 4;
  localparam int WRITE_FRAME_LEN = 8;
  localparam int DATA_BYTES      = 4;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } uar_state_e;

endpackage

`default_nettype wire

// File: rtl/uar_byte_timer.sv
// ============================================================================
// uar_byte_timer : inter-byte timeout counter, pulses expire at TIMEOUT_CYCLES-1
// Revision : 1.0
// ============================================================================
`default_nettype none

module uar_byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A clearing byte in the expiry cycle suppresses the timeout.
  assign expire = en && !clr && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr || expire || !en) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uar_cmd_decoder.sv
// ============================================================================
// uar_cmd_decoder : assembles framed host commands from the UART byte stream
// Optional error counter enabled by macro UAR_CMD_DECODER_ERR_CNT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module uar_cmd_decoder
  import uar_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ       = CMD_READ_DEF,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_ferr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        csum_err,
  output logic        cmd_err,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic        rx_err
`ifdef UAR_CMD_DECODER_ERR_CNT_EN
  ,
  input  logic        err_clr,
  output logic [7:0]  err_count
`endif
);

  uar_state_e  state_q, state_d;
  logic [7:0]  csum_q, csum_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  bcnt_q, bcnt_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_write_q, cmd_write_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_data_q, cmd_data_d;

  logic        csum_err_q, csum_err_d;
  logic        cmd_err_q, cmd_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_err_q, overrun_err_d;
  logic        rx_err_q, rx_err_d;

  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expire;
  logic        frame_done;

  assign tmr_clr = in_valid || in_ferr;
  assign tmr_en  = (state_q != HUNT);

  uar_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_byte_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d       = state_q;
    csum_d        = csum_q;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    data_d        = data_q;
    bcnt_d        = bcnt_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    csum_err_d    = 1'b0;
    cmd_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;
    rx_err_d      = 1'b0;
    frame_done    = 1'b0;

    // Framing error outranks a coincident byte and aborts any partial frame.
    if (in_ferr) begin
      rx_err_d = 1'b1;
      state_d  = HUNT;
    end else if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_data == SYNC_BYTE) begin
            state_d = CMD;
            csum_d  = '0;
            data_d  = '0;
            bcnt_d  = '0;
          end
        end
        CMD: begin
          if ((in_data == CMD_WRITE) || (in_data == CMD_READ)) begin
            is_write_d = (in_data == CMD_WRITE);
            csum_d     = csum_q ^ in_data;
            state_d    = ADDR;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = HUNT;
          end
        end
        ADDR: begin
          addr_d  = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = is_write_q ? DATA : CSUM;
        end
        DATA: begin
          // Little-endian: shifting in from the top leaves D0 in the low byte.
          data_d = {in_data, data_q[31:8]};
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(DATA_BYTES - 1)) begin
            state_d = CSUM;
          end
        end
        CSUM: begin
          state_d = HUNT;
          if (in_data == csum_q) begin
            frame_done = 1'b1;
          end else begin
            csum_err_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (tmr_expire) begin
      timeout_err_d = 1'b1;
      state_d       = HUNT;
    end

    // A completion coinciding with a handshake replaces the accepted command.
    if (frame_done) begin
      if (cmd_valid_q && !cmd_ready) begin
        overrun_err_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_write_d = is_write_q;
        cmd_addr_d  = addr_q;
        cmd_data_d  = is_write_q ? data_q : 32'd0;
      end
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      csum_q        <= '0;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      bcnt_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      csum_err_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      csum_q        <= csum_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      bcnt_q        <= bcnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      csum_err_q    <= csum_err_d;
      cmd_err_q     <= cmd_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      rx_err_q      <= rx_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign csum_err    = csum_err_q;
  assign cmd_err     = cmd_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_err      = rx_err_q;

`ifdef UAR_CMD_DECODER_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       any_err;

  assign any_err = csum_err_q | cmd_err_q | timeout_err_q | overrun_err_q | rx_err_q;

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (any_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

`default_nettype wire
